// File: rtl/cr_structs.sv
// Shared constants and types for the cr_* read-side stream stages.
package cr_structs;

  localparam int CR_SKID_DEPTH = 2;

  typedef logic [1:0] cr_skid_occ_t;

endpackage

// File: rtl/cr_skid_buf2.sv
// Two-entry skid buffer: storage, 1-bit rd/wr pointers and occupancy count.
module cr_skid_buf2
  import cr_structs::*;
#(
  parameter int N_DATA_BITS = 64
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic [N_DATA_BITS-1:0] push_data,
  input  logic                   pop,
  input  logic                   flush,
  output logic                   valid,
  output logic [N_DATA_BITS-1:0] data,
  output cr_skid_occ_t           occ
);

  logic [N_DATA_BITS-1:0] mem [CR_SKID_DEPTH];
  logic                   wr_ptr;
  logic                   rd_ptr;

  // NOTE: storage is only two words, so it is reset with the control state;
  // this keeps out_data a known 0 after reset instead of X.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      occ    <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      for (int i = 0; i < CR_SKID_DEPTH; i++) mem[i] <= '0;
    end else if (flush) begin
      occ    <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments everywhere here, so occ below uses the
      // pre-edge value no matter how the statements are ordered.
      if (push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      occ <= occ + cr_skid_occ_t'(push) - cr_skid_occ_t'(pop);
    end
  end

  assign valid = (occ != '0);
  assign data  = mem[rd_ptr];

endmodule

// File: rtl/cr_fifo_rd_skid.sv
// Drains a show-ahead FIFO into a valid/ready stream through a 2-entry skid
// buffer, tagging sop/eop from a fixed beat count and counting stall cycles.
module cr_fifo_rd_skid
  import cr_structs::*;
#(
  parameter int N_DATA_BITS  = 64,
  parameter int N_PKT_BEATS  = 4,
  parameter int N_STALL_BITS = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_DATA_BITS-1:0]  fifo_rdata,
  input  logic                    fifo_empty,
  output logic                    fifo_ren,
  output logic                    out_valid,
  output logic [N_DATA_BITS-1:0]  out_data,
  output logic                    out_sop,
  output logic                    out_eop,
  input  logic                    out_ready,
  input  logic                    flush,
  output logic [N_STALL_BITS-1:0] stall_cnt,
  output logic                    busy
);

  localparam int                BEAT_W    = (N_PKT_BEATS > 1) ? $clog2(N_PKT_BEATS) : 1;
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(N_PKT_BEATS - 1);

  cr_skid_occ_t      occ;
  logic              pop;
  logic [BEAT_W-1:0] beat;

  // The pop decision uses only registered occupancy, never out_ready, so the
  // FIFO read enable stays free of any path from the consumer.
  assign fifo_ren = ~rst & ~fifo_empty & (occ < cr_skid_occ_t'(CR_SKID_DEPTH)) & ~flush;
  assign pop      = out_valid & out_ready & ~flush;
  assign busy     = (occ != '0);

  cr_skid_buf2 #(
    .N_DATA_BITS (N_DATA_BITS)
  ) u_buf (
    .clk       (clk),
    .rst       (rst),
    .push      (fifo_ren),
    .push_data (fifo_rdata),
    .pop       (pop),
    .flush     (flush),
    .valid     (out_valid),
    .data      (out_data),
    .occ       (occ)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      beat <= '0;
    end else if (flush) begin
      beat <= '0;
    end else if (pop) begin
      beat <= (beat == LAST_BEAT) ? '0 : beat + BEAT_W'(1);
    end
  end

  assign out_sop = out_valid & (beat == '0);
  assign out_eop = out_valid & (beat == LAST_BEAT);

  // Stall history survives flush; only reset clears it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt <= '0;
    end else if (out_valid & ~out_ready & ~(&stall_cnt)) begin
      stall_cnt <= stall_cnt + N_STALL_BITS'(1);
    end
  end

endmodule

// File: tb/tb_cr_fifo_rd_skid.sv
// Self-checking bench for cr_fifo_rd_skid: an upstream FIFO queue, a queue
// model of the buffered words and a delivered-word count drive expectations.
module tb_cr_fifo_rd_skid;

  localparam int DW    = 64;
  localparam int BEATS = 4;
  localparam int SW    = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [DW-1:0] fifo_rdata;
  logic          fifo_empty;
  logic          fifo_ren;
  logic          out_valid;
  logic [DW-1:0] out_data;
  logic          out_sop;
  logic          out_eop;
  logic          out_ready;
  logic          flush;
  logic [SW-1:0] stall_cnt;
  logic          busy;

  cr_fifo_rd_skid #(
    .N_DATA_BITS  (DW),
    .N_PKT_BEATS  (BEATS),
    .N_STALL_BITS (SW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .fifo_rdata (fifo_rdata),
    .fifo_empty (fifo_empty),
    .fifo_ren   (fifo_ren),
    .out_valid  (out_valid),
    .out_data   (out_data),
    .out_sop    (out_sop),
    .out_eop    (out_eop),
    .out_ready  (out_ready),
    .flush      (flush),
    .stall_cnt  (stall_cnt),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  logic [DW-1:0] up_q [$];
  logic [DW-1:0] buf_q [$];
  int            delivered;
  logic [SW-1:0] m_stall;
  int            passed = 0;
  int            total  = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // Drive one cycle, check outputs at the negedge, advance the model at posedge.
  task automatic step(input logic rdy, input logic fl, input logic hide);
    logic e_valid, e_ren, e_pop;
    out_ready  = rdy;
    flush      = fl;
    fifo_empty = hide || (up_q.size() == 0);
    fifo_rdata = fifo_empty ? '0 : up_q[0];
    @(negedge clk);
    e_valid = (buf_q.size() != 0);
    e_ren   = !fifo_empty && (buf_q.size() < 2) && !fl;
    e_pop   = e_valid && rdy && !fl;
    check("out_valid", 64'(out_valid), 64'(e_valid));
    check("fifo_ren",  64'(fifo_ren),  64'(e_ren));
    check("busy",      64'(busy),      64'(e_valid));
    check("out_sop",   64'(out_sop),   64'(e_valid && (delivered % BEATS == 0)));
    check("out_eop",   64'(out_eop),   64'(e_valid && (delivered % BEATS == BEATS - 1)));
    check("stall_cnt", 64'(stall_cnt), 64'(m_stall));
    if (e_valid) check("out_data", out_data, buf_q[0]);
    @(posedge clk);
    if (e_valid && !rdy && m_stall != '1) m_stall++;
    if (fl) begin
      buf_q.delete();
      delivered = 0;
    end else begin
      if (e_pop) begin
        void'(buf_q.pop_front());
        delivered++;
      end
      if (e_ren) buf_q.push_back(up_q.pop_front());
    end
    #1;
  endtask

  task automatic clear_model();
    up_q.delete();
    buf_q.delete();
    delivered = 0;
    m_stall   = '0;
  endtask

  task automatic reset_dut();
    rst        = 1'b1;
    out_ready  = 1'b0;
    flush      = 1'b0;
    fifo_empty = 1'b1;
    fifo_rdata = '0;
    clear_model();
    @(negedge clk);
    check("rst_valid", 64'(out_valid), 64'd0);
    check("rst_data",  out_data,       64'd0);
    check("rst_sop",   64'(out_sop),   64'd0);
    check("rst_eop",   64'(out_eop),   64'd0);
    check("rst_busy",  64'(busy),      64'd0);
    check("rst_stall", 64'(stall_cnt), 64'd0);
    check("rst_ren",   64'(fifo_ren),  64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic drain(input int max_cycles);
    for (int i = 0; i < max_cycles && (up_q.size() != 0 || buf_q.size() != 0); i++)
      step(1'b1, 1'b0, 1'b0);
    check("drained_busy", 64'(busy), 64'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset_dut();

    // Straight stream: 8 words with the consumer always ready.
    for (int i = 0; i < 8; i++) up_q.push_back(DW'(i));
    for (int i = 0; i < 9; i++) step(1'b1, 1'b0, 1'b0);
    check("stream_done_busy", 64'(busy), 64'd0);

    // Back-pressure: five not-ready cycles counted from the first valid one.
    for (int i = 0; i < 6; i++) up_q.push_back(DW'(32'h100 + i));
    step(1'b0, 1'b0, 1'b0);
    repeat (5) step(1'b0, 1'b0, 1'b0);
    check("bp_stall", 64'(stall_cnt), 64'd5);
    check("bp_hold",  out_data,       64'h100);
    drain(20);

    // Alternating ready over 10 words.
    for (int i = 0; i < 10; i++) up_q.push_back(DW'(32'h200 + i));
    for (int i = 0; i < 24; i++) step(1'(i % 2 == 0), 1'b0, 1'b0);
    drain(20);

    // Flush with two words buffered and one beat already delivered.
    reset_dut();
    for (int i = 0; i < 6; i++) up_q.push_back(DW'(32'h300 + i));
    step(1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    check("flush_busy",  64'(busy),      64'd0);
    check("flush_stall", 64'(stall_cnt), 64'd1);
    step(1'b1, 1'b0, 1'b0);
    check("flush_sop",  64'(out_sop), 64'd1);
    check("flush_word", out_data,     64'h303);
    drain(20);

    // Stall counter saturation.
    reset_dut();
    up_q.push_back(64'hdead_beef_0000_0001);
    repeat (21) step(1'b0, 1'b0, 1'b0);
    check("sat_stall", 64'(stall_cnt), 64'd15);
    drain(10);

    // Asynchronous reset between edges with the buffer full.
    reset_dut();
    for (int i = 0; i < 8; i++) up_q.push_back(DW'(32'h400 + i));
    repeat (3) step(1'b0, 1'b0, 1'b0);
    check("pre_arst_busy", 64'(busy), 64'd1);
    #2;
    rst = 1'b1;
    #1;
    check("arst_valid", 64'(out_valid), 64'd0);
    check("arst_ren",   64'(fifo_ren),  64'd0);
    check("arst_busy",  64'(busy),      64'd0);
    check("arst_stall", 64'(stall_cnt), 64'd0);
    clear_model();
    fifo_empty = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int i = 0; i < 8; i++) up_q.push_back({$urandom, $urandom});
    drain(20);

    // Randomized traffic with upstream gaps, back-pressure and sporadic flush.
    for (int i = 0; i < 30; i++) up_q.push_back({$urandom, $urandom});
    for (int i = 0; i < 80; i++)
      step(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 15) == 0),
           1'($urandom_range(0, 4) == 0));
    drain(80);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/cr_fifo_rd_skid.md
Name: cr_fifo_rd_skid

Overview:
- Read-side drain stage placed directly downstream of a standard show-ahead FIFO wrapper.
- Pops words with a registered-decision read enable and holds them in a 2-entry skid buffer.
- Presents them to the consumer over a valid/ready stream, tagging packet boundaries from a fixed beat count.
- The FIFO's read enable never depends combinationally on the consumer's ready.

Parameters:
N_DATA_BITS, 64, width of FIFO word and output data
N_PKT_BEATS, 4, beats per packet for sop/eop tagging; legal range 1..256
N_STALL_BITS, 16, width of saturating back-pressure stall counter

Ports:
clk  input  1  clock
rst  input  1  asynchronous active-high reset
fifo_rdata  input  N_DATA_BITS  show-ahead head word of upstream FIFO, valid whenever fifo_empty=0
fifo_empty  input  1  upstream FIFO empty
fifo_ren  output  1  pop upstream FIFO this cycle
out_valid  output  1  output word valid
out_data  output  N_DATA_BITS  output word
out_sop  output  1  first beat of packet (qualified by out_valid)
out_eop  output  1  last beat of packet (qualified by out_valid)
out_ready  input  1  consumer accepts when out_valid & out_ready
flush  input  1  synchronous discard of buffered data and packet position
stall_cnt  output  N_STALL_BITS  saturating count of cycles with out_valid & ~out_ready
busy  output  1  buffer occupancy != 0

Behaviour:
- Reset is asynchronous and active-high, on clk.
- Reset values: occupancy 0, rd/wr pointers 0, beat counter 0, stall_cnt 0. Therefore out_valid=0, out_sop=0, out_eop=0, busy=0, fifo_ren=0. Storage resets to 0, so out_data=0.
- Buffer: 2 entries, 1-bit rd/wr pointers, occupancy counter 0..2.
- fifo_ren = ~fifo_empty & (occ < 2) & ~flush.
  - Depends only on registered occ, fifo_empty and flush; never on out_ready.
- Push: when fifo_ren=1, fifo_rdata is written to entry wr_ptr in the same cycle and wr_ptr toggles.
- Pop: when out_valid & out_ready & ~flush, rd_ptr toggles.
- Occupancy: occ_next = occ + push - pop. Simultaneous push and pop leaves occ unchanged.
- Outputs: out_valid = (occ != 0); out_data = entry[rd_ptr]. Both are register-sourced, no combinational path from the input side.
- Latency: a word at the FIFO head with the buffer empty appears on out_valid on the next cycle.
- Throughput: one word per cycle sustained while fifo_empty=0 and out_ready=1 (occ steady at 1).
- Back-pressure: with out_ready=0, occ rises to 2 and fifo_ren deasserts. No data is lost; out_data is held stable while out_valid & ~out_ready.
- Beat counter:
  - Width clog2(N_PKT_BEATS), counts 0..N_PKT_BEATS-1.
  - Increments on pop and wraps to 0 after the pop where it equals N_PKT_BEATS-1.
  - out_sop = out_valid & (beat==0); out_eop = out_valid & (beat==N_PKT_BEATS-1).
  - If N_PKT_BEATS=1, sop=eop=out_valid.
- stall_cnt increments on each cycle with out_valid & ~out_ready and saturates at all-ones. It clears only on rst, not on flush.
- flush=1:
  - occ, pointers and beat counter go to 0 next cycle.
  - fifo_ren is forced 0 and any handshake that cycle is not counted as a pop.
  - out_valid may be 1 during the flush cycle; consumers ignore it.
- Reset mid-operation: all state returns to the reset values immediately; buffered words are lost.
- No overflow is possible: push occurs only when occ<2 or occ stays equal through a simultaneous pop.
- Pop with occ=0 is impossible because out_valid=0.

Decomposition:
- Shared package cr_structs gains:
  - constant CR_SKID_DEPTH=2;
  - typedef for the occupancy count, cr_skid_occ_t, logic [1:0].
- One natural sub-module: cr_skid_buf2. It holds the 2-entry storage, pointers and occupancy, with push/pop/flush in and valid/data/occ out.
- Beat counter, sop/eop decode, stall counter and the ren equation stay in the top.

Test Plan:
- Stream: FIFO holds 8 words 0x0..0x7, out_ready=1 constantly -> fifo_ren high for 8 consecutive cycles. out_valid from cycle 1 for 8 cycles with data 0..7. sop on beats 0 and 4, eop on beats 3 and 7.
- Back-pressure: 6 words queued, out_ready=0 for 5 cycles then 1 -> fifo_ren high exactly 2 cycles, occ=2, out_data held at word 0. stall_cnt=5 (from first valid cycle); then words 0..5 delivered in order, none lost or duplicated.
- Alternating ready: out_ready toggles 1/0 with 10 words -> all 10 delivered in order, fifo_ren never asserted while occ=2.
- Flush: 2 words buffered and beat=1, flush for 1 cycle with out_ready=1 -> fifo_ren=0 that cycle and occ=0 afterwards. The next word delivered carries out_sop=1; stall_cnt unchanged.
- Saturation: N_STALL_BITS=4, out_ready=0 for 20 cycles with out_valid=1 -> stall_cnt reaches 15 and holds.
- Async reset: assert rst mid-stream with occ=2 between clock edges -> out_valid, fifo_ren, busy and stall_cnt are 0 immediately. After release, a full stream restarts with sop on the first beat.
